// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative shift-add multiply / restoring divide sequencer writing HI/LO.
// Signed MULT/DIV support is compiled in when MULDIV_SIGNED_EN is defined.
module muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] mq;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] hi_r, lo_r;
    logic              dz;
    logic              accept;
    logic [DATA_W-1:0] mag1, mag2;

    // acc/mq hold {acc,multiplier} for multiply and {remainder,quotient} for divide
    logic [DATA_W:0]   mul_add, mul_sum, step_acc, div_acc_n;
    logic [DATA_W-1:0] step_mq, div_mq_n;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] trial;
    logic              borrow;
    logic [DATA_W-1:0] fin_hi, fin_lo;

    assign accept = start_i && !flush_i;

`ifdef MULDIV_SIGNED_EN
    logic s1, s2, neg_lo, neg_hi;
    logic [2*DATA_W-1:0] prod_neg;
    assign s1   = op_i[0] & src1_i[DATA_W-1];
    assign s2   = op_i[0] & src2_i[DATA_W-1];
    assign mag1 = s1 ? -src1_i : src1_i;
    assign mag2 = s2 ? -src2_i : src2_i;
`else
    logic unused_sign;
    assign unused_sign = op_i[0];
    assign mag1 = src1_i;
    assign mag2 = src2_i;
`endif

    always_comb begin
        mul_add   = mq[0] ? {1'b0, opnd} : '0;
        mul_sum   = acc + mul_add;
        rem_sh    = {acc[DATA_W-1:0], mq[DATA_W-1]};
        trial     = {1'b0, rem_sh} - {2'b00, opnd};
        borrow    = trial[DATA_W+1];
        div_acc_n = borrow ? {1'b0, rem_sh[DATA_W-1:0]} : trial[DATA_W:0];
        div_mq_n  = {mq[DATA_W-2:0], ~borrow};
        if (is_div) begin
            step_acc = div_acc_n;
            step_mq  = div_mq_n;
        end else begin
            step_acc = {1'b0, mul_sum[DATA_W:1]};
            step_mq  = {mul_sum[0], mq[DATA_W-1:1]};
        end
        fin_hi = step_acc[DATA_W-1:0];
        fin_lo = step_mq;
`ifdef MULDIV_SIGNED_EN
        // sign fix-up rides on the final step so latency matches the unsigned path
        prod_neg = -{step_acc[DATA_W-1:0], step_mq};
        if (is_div) begin
            if (neg_lo) fin_lo = -step_mq;
            if (neg_hi) fin_hi = -step_acc[DATA_W-1:0];
        end else if (neg_lo) begin
            {fin_hi, fin_lo} = prod_neg;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            mq     <= '0;
            opnd   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= step_acc;
                        mq  <= step_mq;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state <= S_DONE;
                            hi_r  <= fin_hi;
                            lo_r  <= fin_lo;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op_i[1];
                        acc    <= '0;
                        mq     <= op_i[1] ? mag1 : mag2;
                        opnd   <= op_i[1] ? mag2 : mag1;
`ifdef MULDIV_SIGNED_EN
                        neg_lo <= s1 ^ s2;
                        neg_hi <= s1;
`endif
                        if (op_i[1] && src2_i == '0) begin
                            state <= S_DONE;
                            hi_r  <= src1_i;
                            lo_r  <= '1;
                            dz    <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            dz    <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_o     = (state == S_RUN);
    assign done_o     = (state == S_DONE);
    assign div_zero_o = dz;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that extends the single-cycle MIPS datapath with MULTU/DIVU (MULT/DIV when the optional feature is enabled), writing HI/LO.
- Issued by the decoder with a start pulse. Runs one shift-add or shift-subtract step per cycle on a private adder.
- Holds busy_o so the control unit stalls PC/IF until done_o.
- The result is held on hi_o/lo_o for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand/result width; must be >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE or DONE
- op_i  input  2  bit1: 0=multiply, 1=divide; bit0: 1=signed (honoured only with feature)
- src1_i  input  DATA_W  rs operand (multiplicand / dividend)
- src2_i  input  DATA_W  rt operand (multiplier / divisor)
- flush_i  input  1  abort in-flight operation
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle completion pulse
- div_zero_o  output  1  set on completion of a divide with src2_i==0; held until next accepted start
- hi_o  output  DATA_W  HI register (product upper half / remainder)
- lo_o  output  DATA_W  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0, counter=0. Reset overrides start_i/flush_i in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 latches operands and op, clears div_zero_o, counter=0, goes to RUN. Divide with src2_i==0 goes to DONE instead.
- RUN: one step per cycle. Goes to DONE when counter==DATA_W-1 on that edge, i.e. exactly DATA_W RUN cycles.
- DONE: done_o=1 for exactly this one cycle; hi_o/lo_o are valid. start_i=1 here is accepted as in IDLE (back-to-back). Otherwise goes to IDLE.
- Latency: start accepted at edge T gives RUN at T+1..T+DATA_W and done_o at cycle T+DATA_W+1. Divide-by-zero gives done_o at T+1.
- Multiply (shift-add): internal acc (DATA_W+1 bits incl. carry) = 0, mq = multiplier.
  - Each step: if mq[0], acc += multiplicand.
  - Then {acc,mq} >>= 1, logical.
  - At the end, hi = upper DATA_W, lo = lower DATA_W of the 2*DATA_W product. No overflow is possible.
- Divide (restoring): rem = 0, q = dividend.
  - Each step: {rem,q} <<= 1; trial = rem - divisor (DATA_W+1 bits).
  - If no borrow, rem = trial and q[0] = 1.
  - At the end, hi = remainder, lo = quotient.
- Divide by zero: hi_o = dividend, lo_o = all ones, div_zero_o = 1.
- hi_o/lo_o update only on the transition into DONE. They are stable in IDLE and RUN and hold the previous result while a new operation runs.
- flush_i=1 in RUN: goes to IDLE next edge, no done_o, hi_o/lo_o/div_zero_o unchanged.
- flush_i in IDLE/DONE: no effect except that it suppresses acceptance of a simultaneous start_i.
- start_i in RUN is ignored; no queuing.
- Operands are latched at acceptance; later src changes are ignored.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op_i[0]=1 selects signed operation. Magnitudes are taken at acceptance; result signs are recorded.
  - Negation fix-up is applied combinationally on the RUN-to-DONE transition, so latency is unchanged.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2. Remainder sign = dividend sign.
  - Most-negative / -1 yields lo = most-negative, hi = 0.
  - Signed divide by zero behaves as unsigned divide by zero.
- Undefined: op_i[0] is ignored and all operations are unsigned; no sign logic is present.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, DATA_W=32 -> done_o at T+33; hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o high for exactly 32 cycles.
- DIVU 100 / 7 -> done_o at T+33; hi_o=2, lo_o=14, div_zero_o=0.
- DIVU 0x1234 / 0 -> done_o at T+1; hi_o=0x1234, lo_o=0xFFFFFFFF, div_zero_o=1; next accepted start clears div_zero_o.
- MULTU 3x5 completes (lo_o=15). start_i held high in DONE with DIVU 9/2 -> accepted with no IDLE cycle; lo_o stays 15 until second done_o, then hi_o=1, lo_o=4.
- Flush and reset:
  - Start MULTU 6x7, assert flush_i at RUN cycle 10 -> IDLE, no done_o, hi_o/lo_o keep prior values.
  - rst_i mid-RUN -> all outputs 0 next cycle.
- With MULDIV_SIGNED_EN: MULT -3 x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Without the macro, the same op_i gives unsigned results.
